// File: rtl/mem_access_if.sv
// Bundles the pipeline-side, data-memory and MEM/WB signals of the memory access stage.
// slave is the stage itself; master is whatever drives the pipeline and serves the memory.
interface mem_access_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  valid_in;
    logic [3:0]            mem_op_in;
    logic [31:0]           mem_addr_in;
    logic [31:0]           store_data_in;
    logic [REG_ADDR_W-1:0] dest_addr_in;
    logic                  wreg_in;
    logic [31:0]           dest_data_in;
    logic [31:0]           hi_in;
    logic [31:0]           lo_in;
    logic                  whilo_in;

    logic                  dmem_req;
    logic                  dmem_we;
    logic [3:0]            dmem_be;
    logic [31:0]           dmem_addr;
    logic [31:0]           dmem_wdata;
    logic [31:0]           dmem_rdata;
    logic                  dmem_ack;

    logic                  stall_req;

    logic                  valid_out;
    logic [REG_ADDR_W-1:0] dest_addr_out;
    logic                  wreg_out;
    logic [31:0]           dest_data_out;
    logic [31:0]           hi_out;
    logic [31:0]           lo_out;
    logic                  whilo_out;
    logic [1:0]            excp_out;

    modport slave (
        input  valid_in, mem_op_in, mem_addr_in, store_data_in, dest_addr_in,
        input  wreg_in, dest_data_in, hi_in, lo_in, whilo_in,
        input  dmem_rdata, dmem_ack,
        output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        output stall_req,
        output valid_out, dest_addr_out, wreg_out, dest_data_out,
        output hi_out, lo_out, whilo_out, excp_out
    );

    modport master (
        output valid_in, mem_op_in, mem_addr_in, store_data_in, dest_addr_in,
        output wreg_in, dest_data_in, hi_in, lo_in, whilo_in,
        output dmem_rdata, dmem_ack,
        input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        input  stall_req,
        input  valid_out, dest_addr_out, wreg_out, dest_data_out,
        input  hi_out, lo_out, whilo_out, excp_out
    );
endinterface

// File: rtl/mem_access.sv
// MEM pipeline stage: issues byte/half/word loads and stores to a data memory with an
// ack handshake and bounded wait, and registers the MEM/WB fields.
module mem_access #(
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 15
) (
    input  logic        clk,
    input  logic        rst,
    mem_access_if.slave bus
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic logic is_mem(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_SW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] lane);
        case (op)
            OP_LH, OP_LHU, OP_SH: return lane[0];
            OP_LW, OP_SW:         return (lane != 2'b00);
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [3:0] op, input logic [1:0] lane);
        case (op)
            OP_SB:   return 4'b0001 << lane;
            OP_SH:   return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [3:0] op, input logic [31:0] d);
        case (op)
            OP_SB:   return {4{d[7:0]}};
            OP_SH:   return {2{d[15:0]}};
            OP_SW:   return d;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] load_fmt(input logic [3:0] op, input logic [1:0] lane,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        case (op)
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'd0, b};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_cnt;
    logic [7:0]            w_cnt_nxt;

    logic [3:0]            r_op;
    logic [1:0]            r_lane;
    logic [REG_ADDR_W-1:0] r_dest_addr;
    logic                  r_wreg;
    logic [31:0]           r_dest_data;
    logic [31:0]           r_hi;
    logic [31:0]           r_lo;
    logic                  r_whilo;

    logic                  r_dmem_req;
    logic                  r_dmem_we;
    logic [3:0]            r_dmem_be;
    logic [31:0]           r_dmem_addr;
    logic [31:0]           r_dmem_wdata;

    logic                  r_valid_out;
    logic [REG_ADDR_W-1:0] r_dest_addr_out;
    logic                  r_wreg_out;
    logic [31:0]           r_dest_data_out;
    logic [31:0]           r_hi_out;
    logic [31:0]           r_lo_out;
    logic                  r_whilo_out;
    logic [1:0]            r_excp_out;

    logic                  w_in_mem;
    logic                  w_in_misal;
    logic                  w_launch;
    logic                  w_pass;
    logic                  w_misal;
    logic                  w_bubble;
    logic                  w_done;
    logic                  w_tmo;
    logic                  w_stall;

    assign w_in_mem   = is_mem(bus.mem_op_in);
    assign w_in_misal = misaligned(bus.mem_op_in, bus.mem_addr_in[1:0]);

    // State register and BUSY cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, counter and one-hot action strobes; stall drops on the completing cycle
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_launch    = 1'b0;
        w_pass      = 1'b0;
        w_misal     = 1'b0;
        w_bubble    = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = 8'd0;
                if (!bus.valid_in) begin
                    w_bubble = 1'b1;
                end else if (!w_in_mem) begin
                    w_pass = 1'b1;
                end else if (w_in_misal) begin
                    w_misal = 1'b1;
                end else begin
                    w_launch    = 1'b1;
                    w_stall     = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.dmem_ack) begin
                    w_done      = 1'b1;
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_tmo       = 1'b1;
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Latched instruction, memory request and MEM/WB output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op            <= 4'd0;
            r_lane          <= 2'd0;
            r_dest_addr     <= '0;
            r_wreg          <= 1'b0;
            r_dest_data     <= 32'd0;
            r_hi            <= 32'd0;
            r_lo            <= 32'd0;
            r_whilo         <= 1'b0;
            r_dmem_req      <= 1'b0;
            r_dmem_we       <= 1'b0;
            r_dmem_be       <= 4'd0;
            r_dmem_addr     <= 32'd0;
            r_dmem_wdata    <= 32'd0;
            r_valid_out     <= 1'b0;
            r_dest_addr_out <= '0;
            r_wreg_out      <= 1'b0;
            r_dest_data_out <= 32'd0;
            r_hi_out        <= 32'd0;
            r_lo_out        <= 32'd0;
            r_whilo_out     <= 1'b0;
            r_excp_out      <= 2'b00;
        end else if (w_launch) begin
            r_op         <= bus.mem_op_in;
            r_lane       <= bus.mem_addr_in[1:0];
            r_dest_addr  <= bus.dest_addr_in;
            r_wreg       <= bus.wreg_in;
            r_dest_data  <= bus.dest_data_in;
            r_hi         <= bus.hi_in;
            r_lo         <= bus.lo_in;
            r_whilo      <= bus.whilo_in;
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= is_store(bus.mem_op_in);
            r_dmem_be    <= store_be(bus.mem_op_in, bus.mem_addr_in[1:0]);
            r_dmem_addr  <= {bus.mem_addr_in[31:2], 2'b00};
            r_dmem_wdata <= store_wdata(bus.mem_op_in, bus.store_data_in);
            r_valid_out  <= 1'b0;
            r_wreg_out   <= 1'b0;
            r_whilo_out  <= 1'b0;
            r_excp_out   <= 2'b00;
        end else if (w_done) begin
            r_dmem_req      <= 1'b0;
            r_dmem_we       <= 1'b0;
            r_valid_out     <= 1'b1;
            r_excp_out      <= 2'b00;
            r_dest_addr_out <= r_dest_addr;
            r_wreg_out      <= r_wreg;
            r_whilo_out     <= r_whilo;
            r_hi_out        <= r_hi;
            r_lo_out        <= r_lo;
            r_dest_data_out <= is_store(r_op) ? r_dest_data : load_fmt(r_op, r_lane, bus.dmem_rdata);
        end else if (w_tmo) begin
            r_dmem_req      <= 1'b0;
            r_dmem_we       <= 1'b0;
            r_valid_out     <= 1'b1;
            r_wreg_out      <= 1'b0;
            r_whilo_out     <= 1'b0;
            r_excp_out      <= 2'b10;
            r_dest_addr_out <= r_dest_addr;
            r_dest_data_out <= r_dest_data;
            r_hi_out        <= r_hi;
            r_lo_out        <= r_lo;
        end else if (w_pass || w_misal) begin
            r_valid_out     <= 1'b1;
            r_dest_addr_out <= bus.dest_addr_in;
            r_dest_data_out <= bus.dest_data_in;
            r_hi_out        <= bus.hi_in;
            r_lo_out        <= bus.lo_in;
            r_wreg_out      <= w_pass & bus.wreg_in;
            r_whilo_out     <= w_pass & bus.whilo_in;
            r_excp_out      <= w_misal ? 2'b01 : 2'b00;
        end else if (w_bubble) begin
            r_valid_out <= 1'b0;
            r_wreg_out  <= 1'b0;
            r_whilo_out <= 1'b0;
            r_excp_out  <= 2'b00;
        end else begin
            // still waiting for the memory: nothing retires this cycle
            r_valid_out <= 1'b0;
            r_wreg_out  <= 1'b0;
            r_whilo_out <= 1'b0;
        end
    end

    assign bus.stall_req     = w_stall;
    assign bus.dmem_req      = r_dmem_req;
    assign bus.dmem_we       = r_dmem_we;
    assign bus.dmem_be       = r_dmem_be;
    assign bus.dmem_addr     = r_dmem_addr;
    assign bus.dmem_wdata    = r_dmem_wdata;
    assign bus.valid_out     = r_valid_out;
    assign bus.dest_addr_out = r_dest_addr_out;
    assign bus.wreg_out      = r_wreg_out;
    assign bus.dest_data_out = r_dest_data_out;
    assign bus.hi_out        = r_hi_out;
    assign bus.lo_out        = r_lo_out;
    assign bus.whilo_out     = r_whilo_out;
    assign bus.excp_out      = r_excp_out;

endmodule

// File: tb/tb_mem_access.sv
// Randomised scoreboard bench for mem_access: a byte-addressed reference memory predicts
// every retired result and every memory request; a responder serves the bus with chosen delays.
module tb_mem_access;

    localparam int RAW = 5;
    localparam int TMO = 15;

    logic clk;
    logic rst;

    mem_access_if #(.REG_ADDR_W(RAW)) bus ();

    mem_access #(.REG_ADDR_W(RAW), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit             full;
        logic [1:0]     excp;
        logic           wreg;
        logic           whilo;
        logic [RAW-1:0] da;
        logic [31:0]    dd;
        logic [31:0]    hi;
        logic [31:0]    lo;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        int          d;
    } req_t;

    exp_t        exp_q[$];
    req_t        req_q[$];
    logic [7:0]  ref_mem [1024];
    logic [31:0] bus_mem [256];
    int          n_chk = 0;
    int          n_fail = 0;
    bit          abandon = 1'b0;
    logic [3:0]  last_be;
    logic [31:0] last_wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int acc_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd6: return 1;
            4'd3, 4'd4, 4'd7: return 2;
            default:          return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] a);
        logic [31:0] v;
        int n;
        v = 32'd0;
        n = acc_size(op);
        for (int i = 0; i < n; i++)
            v = v | (32'(ref_mem[(int'(a[9:0]) + i) & 1023]) << (8 * i));
        if (op == 4'd1) v = {{24{v[7]}}, v[7:0]};
        if (op == 4'd3) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] word);
        for (int j = 0; j < 4; j++)
            ref_mem[(int'(a[9:0]) + j) & 1023] = word[8*j +: 8];
        bus_mem[a[9:2]] = word;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, 32'({bus.dmem_req, bus.dmem_we, bus.dmem_be, bus.valid_out,
                               bus.wreg_out, bus.whilo_out, bus.excp_out, bus.dest_addr_out,
                               bus.stall_req}), 32'd0);
        chk({tag, "_addr"},  bus.dmem_addr,     32'd0);
        chk({tag, "_wdata"}, bus.dmem_wdata,    32'd0);
        chk({tag, "_dd"},    bus.dest_data_out, 32'd0);
        chk({tag, "_hilo"},  bus.hi_out | bus.lo_out, 32'd0);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input logic [RAW-1:0] da, input logic wr, input logic [31:0] dd,
                         input logic [31:0] hh, input logic [31:0] ll, input logic wh,
                         input int d);
        exp_t e;
        req_t r;
        int   n, exp_st, st, m;
        bit   mem, sto, mis, done;
        n   = acc_size(op);
        mem = (op >= 4'd1) && (op <= 4'd8);
        sto = (op >= 4'd6) && (op <= 4'd8);
        mis = mem && ((int'(a[1:0]) % n) != 0);
        e = '{full: 1'b1, excp: 2'b00, wreg: wr, whilo: wh, da: da, dd: dd, hi: hh, lo: ll};
        exp_st = 0;
        if (mis) begin
            e.full = 1'b0; e.excp = 2'b01; e.wreg = 1'b0; e.whilo = 1'b0;
        end else if (mem) begin
            r.addr = a & 32'hFFFF_FFFC;
            r.we   = sto;
            r.d    = d;
            r.wdata = 32'd0;
            r.be   = 4'hF;
            if (sto) begin
                m = ((1 << n) - 1) << int'(a[1:0]);
                r.be = 4'(m);
                for (int j = 0; j < 4; j++) r.wdata[8*j +: 8] = sd[8*(j % n) +: 8];
            end
            req_q.push_back(r);
            if (d < TMO) begin
                exp_st = 1 + d;
                if (sto) begin
                    for (int i = 0; i < n; i++)
                        ref_mem[(int'(a[9:0]) + i) & 1023] = sd[8*i +: 8];
                end else begin
                    e.dd = ref_load(op, a);
                end
            end else begin
                exp_st = TMO;
                e.full = 1'b0; e.excp = 2'b10; e.wreg = 1'b0; e.whilo = 1'b0;
            end
        end
        exp_q.push_back(e);

        bus.valid_in = 1'b1;     bus.mem_op_in = op;       bus.mem_addr_in = a;
        bus.store_data_in = sd;  bus.dest_addr_in = da;    bus.wreg_in = wr;
        bus.dest_data_in = dd;   bus.hi_in = hh;           bus.lo_in = ll;
        bus.whilo_in = wh;
        st = 0;
        done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (bus.stall_req) st++;
            else done = 1'b1;
            @(posedge clk);
            #1;
            if (!done) begin
                // the stage is now busy and must not look at its inputs
                bus.valid_in = 1'($urandom);     bus.mem_op_in = 4'($urandom);
                bus.mem_addr_in = $urandom;      bus.store_data_in = $urandom;
                bus.dest_addr_in = RAW'($urandom); bus.dest_data_in = $urandom;
                bus.hi_in = $urandom;            bus.lo_in = $urandom;
                bus.wreg_in = 1'($urandom);      bus.whilo_in = 1'($urandom);
            end
        end
        chk("stall_bound", 32'(done), 32'd1);
        chk("stall_cycles", 32'(st), 32'(exp_st));
    endtask

    // scoreboard monitor: one expected entry per retired instruction
    always @(negedge clk) begin
        if (rst) begin
            if (bus.valid_out) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("excp",  32'(bus.excp_out),  32'(e.excp));
                    chk("wreg",  32'(bus.wreg_out),  32'(e.wreg));
                    chk("whilo", 32'(bus.whilo_out), 32'(e.whilo));
                    if (e.full) begin
                        chk("dest_addr", 32'(bus.dest_addr_out), 32'(e.da));
                        chk("dest_data", bus.dest_data_out, e.dd);
                        chk("hi", bus.hi_out, e.hi);
                        chk("lo", bus.lo_out, e.lo);
                    end
                end
            end else begin
                chk("idle_wen", 32'({bus.wreg_out, bus.whilo_out}), 32'd0);
            end
        end
    end

    // memory responder: acks after the delay chosen at issue, checks request stability
    initial begin
        req_t cur;
        int   k;
        bit   in_acc;
        int   w;
        cur = '{addr: 32'd0, wdata: 32'd0, be: 4'd0, we: 1'b0, d: 0};
        k = 0;
        in_acc = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            bus.dmem_ack = 1'b0;
            bus.dmem_rdata = $urandom;
            if (bus.dmem_req) begin
                if (!in_acc) begin
                    in_acc = 1'b1;
                    k = 0;
                    last_be = bus.dmem_be;
                    last_wdata = bus.dmem_wdata;
                    if (req_q.size() == 0) begin
                        chk("unexpected_req", 32'd1, 32'd0);
                        cur = '{addr: 32'd0, wdata: 32'd0, be: 4'd0, we: 1'b0, d: 0};
                    end else begin
                        cur = req_q.pop_front();
                    end
                end else begin
                    k++;
                end
                chk("req_addr", bus.dmem_addr, cur.addr);
                chk("req_be_we", 32'({bus.dmem_be, bus.dmem_we}), 32'({cur.be, cur.we}));
                if (cur.we) chk("req_wdata", bus.dmem_wdata, cur.wdata);
                if (k == cur.d) begin
                    w = int'(bus.dmem_addr[9:2]);
                    bus.dmem_ack = 1'b1;
                    bus.dmem_rdata = bus_mem[w];
                    if (bus.dmem_we) begin
                        for (int j = 0; j < 4; j++)
                            if (bus.dmem_be[j]) bus_mem[w][8*j +: 8] = bus.dmem_wdata[8*j +: 8];
                    end
                    in_acc = 1'b0;
                end
            end else begin
                if (in_acc) begin
                    if (abandon) abandon = 1'b0;
                    else chk("timeout_len", 32'(k + 1), 32'(TMO));
                    in_acc = 1'b0;
                end
                if ($urandom_range(0, 3) == 0) bus.dmem_ack = 1'b1;
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  op;
        int          sel, d;
        rst = 1'b0;
        bus.valid_in = 1'b0;   bus.mem_op_in = 4'd0;    bus.mem_addr_in = 32'd0;
        bus.store_data_in = 32'd0; bus.dest_addr_in = '0; bus.wreg_in = 1'b0;
        bus.dest_data_in = 32'd0;  bus.hi_in = 32'd0;   bus.lo_in = 32'd0;
        bus.whilo_in = 1'b0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++)
            bus_mem[i] = {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
        #2;
        check_zero("reset");
        #10;
        rst = 1'b1;
        @(posedge clk);
        #1;

        issue(4'd0, 32'd0, 32'd0, 5'd3, 1'b1, 32'h1234, 32'h1111_0000, 32'h0000_2222, 1'b0, 0);
        chk("alu_dd", bus.dest_data_out, 32'h0000_1234);
        chk("alu_valid", 32'(bus.valid_out), 32'd1);

        preload(32'h100, 32'h80FF_0000);
        issue(4'd1, 32'h103, 32'd0, 5'd7, 1'b1, 32'h0, 32'd0, 32'd0, 1'b0, 1);
        chk("lb_dd", bus.dest_data_out, 32'hFFFF_FF80);
        chk("lb_be", 32'(last_be), 32'hF);

        issue(4'd7, 32'h202, 32'hAAAA_BEEF, 5'd0, 1'b0, 32'h55, 32'd0, 32'd0, 1'b0, 0);
        chk("sh_be", 32'(last_be), 32'hC);
        chk("sh_wdata", last_wdata, 32'hBEEF_BEEF);
        chk("sh_valid", 32'(bus.valid_out), 32'd1);

        issue(4'd5, 32'h301, 32'd0, 5'd9, 1'b1, 32'd0, 32'd0, 32'd0, 1'b1, 0);
        chk("mis_excp", 32'(bus.excp_out), 32'd1);
        chk("mis_wreg", 32'(bus.wreg_out), 32'd0);

        issue(4'd5, 32'h400, 32'd0, 5'd4, 1'b1, 32'd0, 32'd0, 32'd0, 1'b1, 99);
        chk("tmo_excp", 32'(bus.excp_out), 32'd2);
        chk("tmo_wreg", 32'(bus.wreg_out), 32'd0);
        issue(4'd5, 32'h404, 32'd0, 5'd4, 1'b1, 32'd0, 32'd0, 32'd0, 1'b0, TMO - 1);
        chk("late_ack_excp", 32'(bus.excp_out), 32'd0);

        // reset in the third wait cycle of a load that never gets an ack
        req_q.push_back('{addr: 32'h408, wdata: 32'd0, be: 4'hF, we: 1'b0, d: 99});
        bus.valid_in = 1'b1; bus.mem_op_in = 4'd5; bus.mem_addr_in = 32'h408;
        bus.wreg_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("busy_req", 32'(bus.dmem_req), 32'd1);
        bus.valid_in = 1'b0;
        abandon = 1'b1;
        rst = 1'b0;
        #1;
        check_zero("midbusy_rst");
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        issue(4'd0, 32'd0, 32'd0, 5'd12, 1'b1, 32'hCAFE_0001, 32'd5, 32'd6, 1'b1, 0);
        chk("post_rst_dd", bus.dest_data_out, 32'hCAFE_0001);

        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                bus.valid_in = 1'b0;
                bus.dest_data_in = $urandom;
                bus.wreg_in = 1'($urandom);
                bus.whilo_in = 1'($urandom);
                @(posedge clk);
                #1;
            end else begin
                sel = $urandom_range(0, 19);
                if (sel < 2) op = (sel == 0) ? 4'd0 : 4'($urandom_range(9, 15));
                else op = 4'($urandom_range(1, 8));
                a = $urandom;
                if ($urandom_range(0, 1) == 1) a = a & ~(32'(acc_size(op) - 1));
                sel = $urandom_range(0, 9);
                if (sel < 6)      d = $urandom_range(0, 3);
                else if (sel < 8) d = $urandom_range(4, TMO - 2);
                else if (sel < 9) d = TMO - 1;
                else              d = TMO + 3;
                issue(op, a, $urandom, RAW'($urandom), 1'($urandom), $urandom,
                      $urandom, $urandom, 1'($urandom), d);
            end
        end
        bus.valid_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("req_q_drained", 32'(req_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
